// File: rtl/ks_pkg.sv
// ============================================================================
// Module   : ks_pkg
// Purpose  : Widths and stage payload types for the Kogge-Stone sum/normalize
//            pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ks_pkg;

    localparam int MANT_W = 24;
    localparam int EXP_W  = 8;
    localparam int SUM_W  = MANT_W + 1;
    localparam int LZC_W  = 5;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    typedef struct packed {
        logic [SUM_W-1:0] sum;
        logic             sub;
        logic             sign;
        logic [EXP_W-1:0] exp;
    } s1_t;

    typedef struct packed {
        logic [SUM_W-1:0] mag;
        logic [LZC_W-1:0] lzc;
        logic             sub;
        logic             sign;
        logic [EXP_W-1:0] exp;
    } s2_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
        logic              zero;
        logic              ovf;
    } s3_t;

endpackage

`default_nettype wire

// File: rtl/ks_lzc24.sv
// ============================================================================
// Module   : ks_lzc24
// Purpose  : Combinational 24-bit leading-zero counter; all-zero input gives 24.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ks_lzc24
    import ks_pkg::*;
(
    input  logic [MANT_W-1:0] din,
    output logic [LZC_W-1:0]  count
);

    // Ascending scan: the last set bit seen is the most significant one.
    always_comb begin
        count = LZC_W'(MANT_W);
        for (int i = 0; i < MANT_W; i++) begin
            if (din[i]) begin
                count = LZC_W'(MANT_W - 1 - i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ks_sum_normalize.sv
// ============================================================================
// Module   : ks_sum_normalize
// Purpose  : 3-stage sum / sign-magnitude / normalize pipeline after the last
//            Kogge-Stone prefix stage. Define MAC_FTZ_EN for flush-to-zero
//            underflow; otherwise gradual underflow.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ks_sum_normalize
    import ks_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SUM_W-1:0]  in_G,
    input  logic [SUM_W-1:0]  in_P0,
    input  logic              in_cin,
    input  logic              in_sub,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic              out_zero,
    output logic              out_ovf
);

    logic v1, v2, v3;
    logic ld1, ld2, ld3;
    s1_t  s1_q, s1_d;
    s2_t  s2_q, s2_d;
    s3_t  s3_q, s3_d;
    logic [LZC_W-1:0] lzc;
    logic             neg;

    // Carry out of the top bit is not needed for a zero-extended 25-bit sum.
    logic unused_gtop;
    assign unused_gtop = in_G[SUM_W-1];

    assign ld3      = ~v3 | out_ready;
    assign ld2      = ~v2 | ld3;
    assign ld1      = ~v1 | ld2;
    assign in_ready = ld1;

    always_comb begin
        s1_d      = '0;
        s1_d.sum  = in_P0 ^ {in_G[SUM_W-2:0], in_cin};
        s1_d.sub  = in_sub;
        s1_d.sign = in_sign;
        s1_d.exp  = in_exp;
    end

    always_comb begin
        neg       = s1_q.sub & s1_q.sum[SUM_W-1];
        s2_d      = '0;
        s2_d.mag  = neg ? (~s1_q.sum + SUM_W'(1)) : s1_q.sum;
        s2_d.lzc  = lzc;
        s2_d.sub  = s1_q.sub;
        s2_d.sign = s1_q.sign ^ neg;
        s2_d.exp  = s1_q.exp;
    end

    ks_lzc24 u_lzc (
        .din   (s2_d.mag[MANT_W-1:0]),
        .count (lzc)
    );

`ifndef MAC_FTZ_EN
    logic [EXP_W-1:0] sub_shift;
    assign sub_shift = (s2_q.exp == '0) ? '0 : s2_q.exp - EXP_W'(1);
`endif

    logic [EXP_W:0] exp_inc;
    assign exp_inc = {1'b0, s2_q.exp} + (EXP_W+1)'(1);

    always_comb begin
        s3_d      = '0;
        s3_d.sign = s2_q.sign;
        if (!s2_q.sub && s2_q.mag[SUM_W-1]) begin
            if (exp_inc >= {1'b0, EXP_MAX}) begin
                s3_d.ovf = 1'b1;
                s3_d.exp = EXP_MAX;
            end else begin
                s3_d.mant = s2_q.mag[SUM_W-1:1];
                s3_d.exp  = exp_inc[EXP_W-1:0];
            end
        end else if (s2_q.mag == '0) begin
            s3_d.zero = 1'b1;
            s3_d.sign = 1'b0;
        end else if (EXP_W'(s2_q.lzc) < s2_q.exp) begin
            s3_d.mant = s2_q.mag[MANT_W-1:0] << s2_q.lzc;
            s3_d.exp  = s2_q.exp - EXP_W'(s2_q.lzc);
        end else begin
`ifdef MAC_FTZ_EN
            s3_d.zero = 1'b1;
`else
            s3_d.mant = s2_q.mag[MANT_W-1:0] << sub_shift;
`endif
        end
    end

    // Data registers load only behind a valid beat so idle outputs stay at reset value.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            if (ld1) v1 <= in_valid;
            if (ld2) v2 <= v1;
            if (ld3) v3 <= v2;
            if (ld1 && in_valid) s1_q <= s1_d;
            if (ld2 && v1)       s2_q <= s2_d;
            if (ld3 && v2)       s3_q <= s3_d;
        end
    end

    assign out_valid = v3;
    assign out_sign  = s3_q.sign;
    assign out_exp   = s3_q.exp;
    assign out_mant  = s3_q.mant;
    assign out_zero  = s3_q.zero;
    assign out_ovf   = s3_q.ovf;

endmodule

`default_nettype wire

// File: tb/tb_ks_sum_normalize.sv
// ============================================================================
// Module   : tb_ks_sum_normalize
// Purpose  : Self-checking bench for ks_sum_normalize with an arithmetic model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ks_sum_normalize;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [24:0] in_G = '0;
    logic [24:0] in_P0 = '0;
    logic        in_cin = 1'b0;
    logic        in_sub = 1'b0;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [23:0] out_mant;
    logic        out_zero;
    logic        out_ovf;

    ks_sum_normalize dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_G      (in_G),
        .in_P0     (in_P0),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_mant  (out_mant),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [34:0] obus;
    assign obus = {out_sign, out_exp, out_mant, out_zero, out_ovf};

    logic [23:0] cur_a, cur_b;
    logic        cur_sub, cur_sign;
    logic [7:0]  cur_exp;
    logic [34:0] q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference: plain integer arithmetic on the operands, then the rounding-free
    // normalization rules.
    function automatic logic [34:0] model(input logic [23:0] a, input logic [23:0] b,
                                          input logic sub, input logic sign,
                                          input logic [7:0] e);
        longint m;
        int msb, lz, sh;
        logic s, z, o;
        logic [23:0] mant;
        logic [7:0]  ex;
        s = sign; z = 1'b0; o = 1'b0; mant = '0; ex = '0;
        if (sub) begin
            m = longint'(a) - longint'(b);
            if (m < 0) begin
                m = -m;
                s = ~s;
            end
        end else begin
            m = longint'(a) + longint'(b);
        end
        if (!sub && m >= 64'd16777216) begin
            if (int'(e) + 1 >= 255) begin
                o = 1'b1;
                ex = 8'hFF;
            end else begin
                mant = 24'(m >> 1);
                ex = e + 8'd1;
            end
        end else if (m == 0) begin
            z = 1'b1;
            s = 1'b0;
        end else begin
            msb = 0;
            for (int i = 0; i < 24; i++) if (m[i]) msb = i;
            lz = 23 - msb;
            if (lz < int'(e)) begin
                mant = 24'(m << lz);
                ex = e - 8'(lz);
            end else begin
`ifdef MAC_FTZ_EN
                z = 1'b1;
`else
                sh = (e == 0) ? 0 : int'(e) - 1;
                mant = 24'(m << sh);
`endif
            end
        end
        return {s, ex, mant, z, o};
    endfunction

    task automatic apply(input logic [23:0] a, input logic [23:0] b, input logic sub,
                         input logic sign, input logic [7:0] e);
        logic [24:0] aa, bb;
        longint t, msk;
        aa = {1'b0, a};
        bb = sub ? ~{1'b0, b} : {1'b0, b};
        cur_a = a; cur_b = b; cur_sub = sub; cur_sign = sign; cur_exp = e;
        in_P0 = aa ^ bb;
        in_cin = sub;
        in_sub = sub;
        in_sign = sign;
        in_exp = e;
        for (int i = 0; i < 25; i++) begin
            msk = (longint'(1) << (i + 1)) - 1;
            t = (longint'(aa) & msk) + (longint'(bb) & msk) + longint'(sub);
            in_G[i] = t[i+1];
        end
    endtask

    // Scoreboard: push on accept, pop and compare on drain.
    always @(negedge clock) begin
        if (resetn) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("unexpected_out", 1, 0);
                else check("scoreboard", obus, q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(model(cur_a, cur_b, cur_sub, cur_sign, cur_exp));
        end
    end

    task automatic send(input logic [23:0] a, input logic [23:0] b, input logic sub,
                        input logic sign, input logic [7:0] e);
        int n;
        apply(a, b, sub, sign, e);
        in_valid = 1'b1;
        n = 0;
        @(negedge clock);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clock);
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic [23:0] a, input logic [23:0] b,
                           input logic sub, input logic sign, input logic [7:0] e,
                           input logic [34:0] want, output int lat);
        send(a, b, sub, sign, e);
        lat = 1;
        @(negedge clock);
        while (!out_valid && lat < 20) begin
            lat++;
            @(negedge clock);
        end
        if (!out_valid) check({tag, "_timeout"}, 0, 1);
        else check(tag, obus, want);
        @(posedge clock); #1;
    endtask

    initial begin
        int lat, acc, idx, n;
        logic [34:0] snap;
        logic [23:0] ra, rb;
        logic done;

        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", obus, 0);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;

        run_one("add_carry", 24'h800000, 24'h800000, 1'b0, 1'b0, 8'd127,
                {1'b0, 8'd128, 24'h800000, 1'b0, 1'b0}, lat);
        check("latency", lat, 3);
        run_one("sub_pos", 24'h800000, 24'h400000, 1'b1, 1'b0, 8'd127,
                {1'b0, 8'd126, 24'h800000, 1'b0, 1'b0}, lat);
        run_one("sub_neg", 24'h400000, 24'h800000, 1'b1, 1'b0, 8'd127,
                {1'b1, 8'd126, 24'h800000, 1'b0, 1'b0}, lat);
        run_one("sub_zero", 24'h9ABCDE, 24'h9ABCDE, 1'b1, 1'b1, 8'd100,
                {1'b0, 8'd0, 24'h0, 1'b1, 1'b0}, lat);
`ifdef MAC_FTZ_EN
        run_one("underflow", 24'h000020, 24'h000010, 1'b1, 1'b1, 8'd3,
                {1'b1, 8'd0, 24'h0, 1'b1, 1'b0}, lat);
`else
        run_one("underflow", 24'h000020, 24'h000010, 1'b1, 1'b1, 8'd3,
                {1'b1, 8'd0, 24'h000040, 1'b0, 1'b0}, lat);
`endif
        run_one("overflow", 24'h800000, 24'h800000, 1'b0, 1'b0, 8'd254,
                {1'b0, 8'hFF, 24'h0, 1'b0, 1'b1}, lat);

        // Backpressure: 5 beats offered over 6 stalled cycles.
        out_ready = 1'b0;
        idx = 0; acc = 0;
        for (int c = 0; c < 6; c++) begin
            if (idx < 5) begin
                apply(24'($urandom), 24'($urandom), 1'($urandom), 1'($urandom), 8'($urandom_range(30, 200)));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clock);
            if (in_valid && in_ready) begin
                idx++;
                acc++;
            end
            @(posedge clock); #1;
        end
        @(negedge clock);
        check("bp_accepted", acc, 3);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        snap = obus;
        repeat (2) @(negedge clock);
        check("bp_stable", obus, snap);
        @(posedge clock); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (out_valid) n++;
        end
        check("bp_drain_rate", n, 3);
        @(negedge clock);
        check("bp_empty", out_valid, 0);
        @(posedge clock); #1;

        // Reset in mid-flight discards beats immediately.
        out_ready = 1'b0;
        send(24'h123456, 24'h000111, 1'b0, 1'b0, 8'd50);
        send(24'h700000, 24'h000001, 1'b1, 1'b1, 8'd60);
        @(negedge clock); #2;
        resetn = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_out_data", obus, 0);
        q.delete();
        @(negedge clock);
        resetn = 1'b1;
        out_ready = 1'b1;
        @(posedge clock); #1;

        // Random traffic with random backpressure.
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 250; k++) begin
                    ra = 24'($urandom) >> $urandom_range(0, 23);
                    rb = ($urandom_range(0, 9) == 0) ? ra : 24'($urandom) >> $urandom_range(0, 23);
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clock); #1;
                    end
                    send(ra, rb, 1'($urandom), 1'($urandom),
                         ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 8)) : 8'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clock); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 50) begin
            n++;
            @(negedge clock);
        end
        check("drain_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
